// File: rtl/vga_video_pkg.sv
// Shared video constants and the frame-writer state type, used by both the
// write side and the VGA read side.
package vga_video_pkg;

   localparam int H_DOTS   = 320;
   localparam int V_DOTS   = 240;
   localparam int FB_WORDS = 76800;
   localparam int ADDR_W   = 17;
   localparam int COLOUR_W = 8;
   localparam int X_W      = 9;
   localparam int Y_W      = 8;

   typedef enum logic [1:0] {
      IDLE,
      STORE,
      CLEAR
   } fw_state_t;

endpackage

// File: rtl/vga_frame_writer_if.sv
// Vector store request bus from the vector processor into the frame writer.
interface vga_frame_writer_if #(
   parameter int LANES = 4
) ();
   import vga_video_pkg::*;

   logic                      st_valid;
   logic                      st_ready;
   logic [X_W-1:0]            st_x;
   logic [Y_W-1:0]            st_y;
   logic [COLOUR_W*LANES-1:0] st_data;
   logic [LANES-1:0]          st_mask;

   modport master (
      output st_valid,
      output st_x,
      output st_y,
      output st_data,
      output st_mask,
      input  st_ready
   );

   modport slave (
      input  st_valid,
      input  st_x,
      input  st_y,
      input  st_data,
      input  st_mask,
      output st_ready
   );

endinterface

// File: rtl/vga_dot_address.sv
// Row-major dot address for a 320-wide frame buffer: y*320 + x as two shifts
// and adds, so no multiplier is needed on either the read or the write side.
module vga_dot_address
   import vga_video_pkg::*;
(
   input  logic [X_W-1:0]    x,
   input  logic [Y_W-1:0]    y,
   output logic [ADDR_W-1:0] address
);

   assign address = {1'b0, y, 8'b0} + {3'b0, y, 6'b0} + {8'b0, x};

endmodule

// File: rtl/vga_frame_writer.sv
// Serialises vector pixel stores and full-screen clears into the single write
// port of the dual-port video memory, one registered write per clock.
module vga_frame_writer
   import vga_video_pkg::*;
#(
   parameter int LANES = 4
) (
   input  logic                vga_clock,
   input  logic                reset,
   vga_frame_writer_if.slave   st,
   input  logic                clear_req,
   input  logic [COLOUR_W-1:0] clear_colour,
   output logic                wr_en,
   output logic [ADDR_W-1:0]   wr_address,
   output logic [COLOUR_W-1:0] wr_data,
   output logic                busy,
   output logic                clear_done,
   output logic                st_error
);

   localparam int CNT_W = $clog2(LANES + 1);

   fw_state_t                 state;
   logic [ADDR_W-1:0]         base_address;
   logic [ADDR_W-1:0]         cur_address;
   logic [ADDR_W-1:0]         clear_address;
   logic [X_W:0]              cur_x;
   logic [COLOUR_W*LANES-1:0] data_reg;
   logic [LANES-1:0]          mask_reg;
   logic [CNT_W-1:0]          lanes_left;
   logic [COLOUR_W-1:0]       colour_reg;
   logic                      in_range;
   logic                      accept;

   vga_dot_address u_dot_address (
      .x       (st.st_x),
      .y       (st.st_y),
      .address (base_address)
   );

   assign st.st_ready = (state == IDLE) && !clear_req;
   assign accept      = st.st_valid && st.st_ready;
   assign in_range    = (st.st_x < X_W'(H_DOTS)) && (st.st_y < Y_W'(V_DOTS));
   assign busy        = (state != IDLE);

   // The first write of a store or clear is launched on the accepting edge, so
   // data and mask are kept pre-shifted and lane 0 of the registers is always next.
   always_ff @(posedge vga_clock) begin
      if (reset) begin
         state         <= IDLE;
         wr_en         <= 1'b0;
         wr_address    <= '0;
         wr_data       <= '0;
         clear_done    <= 1'b0;
         st_error      <= 1'b0;
         cur_address   <= '0;
         clear_address <= '0;
         cur_x         <= '0;
         data_reg      <= '0;
         mask_reg      <= '0;
         lanes_left    <= '0;
         colour_reg    <= '0;
      end else begin
         wr_en      <= 1'b0;
         clear_done <= 1'b0;
         st_error   <= 1'b0;
         case (state)
            IDLE: begin
               if (clear_req) begin
                  colour_reg    <= clear_colour;
                  wr_en         <= 1'b1;
                  wr_address    <= '0;
                  wr_data       <= clear_colour;
                  clear_address <= ADDR_W'(1);
                  state         <= CLEAR;
               end else if (accept) begin
                  if (in_range) begin
                     wr_en       <= st.st_mask[0];
                     wr_address  <= base_address;
                     wr_data     <= st.st_data[COLOUR_W-1:0];
                     data_reg    <= st.st_data >> COLOUR_W;
                     mask_reg    <= st.st_mask >> 1;
                     cur_address <= base_address + ADDR_W'(1);
                     cur_x       <= {1'b0, st.st_x} + (X_W+1)'(1);
                     lanes_left  <= CNT_W'(LANES - 1);
                     state       <= STORE;
                  end else begin
                     st_error <= 1'b1;
                  end
               end
            end
            STORE: begin
               // Lanes past the right edge are clipped, never wrapped onto the next row.
               if (lanes_left == '0) begin
                  state <= IDLE;
               end else begin
                  wr_en       <= mask_reg[0] && (cur_x < (X_W+1)'(H_DOTS));
                  wr_address  <= cur_address;
                  wr_data     <= data_reg[COLOUR_W-1:0];
                  data_reg    <= data_reg >> COLOUR_W;
                  mask_reg    <= mask_reg >> 1;
                  cur_address <= cur_address + ADDR_W'(1);
                  cur_x       <= cur_x + (X_W+1)'(1);
                  lanes_left  <= lanes_left - CNT_W'(1);
               end
            end
            CLEAR: begin
               if (clear_address == ADDR_W'(FB_WORDS)) begin
                  clear_done <= 1'b1;
                  state      <= IDLE;
               end else begin
                  wr_en         <= 1'b1;
                  wr_address    <= clear_address;
                  wr_data       <= colour_reg;
                  clear_address <= clear_address + ADDR_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_frame_writer.sv
// Scoreboard bench for vga_frame_writer: a frame-buffer-level model predicts
// every write with its cycle, and a monitor checks each cycle against it.
module tb_vga_frame_writer;

   localparam int LANES = 4;
   localparam int H     = 320;
   localparam int V     = 240;
   localparam int WORDS = 76800;

   typedef struct {
      int cyc;
      int addr;
      int data;
   } wr_t;

   logic        vga_clock;
   logic        reset;
   logic        clear_req;
   logic [7:0]  clear_colour;
   logic        wr_en;
   logic [16:0] wr_address;
   logic [7:0]  wr_data;
   logic        busy;
   logic        clear_done;
   logic        st_error;

   int  cyc;
   int  checks;
   int  errors;
   wr_t exp_q[$];
   bit  err_at[int];
   bit  done_at[int];
   int  busy_from;
   int  busy_to;
   wr_t mon_e;
   bit  mon_busy;

   vga_frame_writer_if #(.LANES(LANES)) st_bus ();

   vga_frame_writer #(.LANES(LANES)) dut (
      .vga_clock    (vga_clock),
      .reset        (reset),
      .st           (st_bus),
      .clear_req    (clear_req),
      .clear_colour (clear_colour),
      .wr_en        (wr_en),
      .wr_address   (wr_address),
      .wr_data      (wr_data),
      .busy         (busy),
      .clear_done   (clear_done),
      .st_error     (st_error)
   );

   initial vga_clock = 1'b0;
   always #5 vga_clock = ~vga_clock;

   initial cyc = 0;
   always @(posedge vga_clock) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h",
                  name, cyc, actual, expected);
      end
   endtask

   // Expected behaviour from the frame-buffer point of view: dot (x+i, y) lives
   // at y*320 + x + i, lanes off the right edge vanish, bad bases only flag.
   task automatic model_store(input int t, input int x, input int y,
                              input logic [31:0] data, input logic [3:0] mask);
      if (x >= H || y >= V) begin
         err_at[t + 1] = 1'b1;
      end else begin
         for (int i = 0; i < LANES; i++) begin
            if (mask[i] && (x + i) < H)
               exp_q.push_back('{t + 1 + i, y * H + x + i, int'(data[8*i +: 8])});
         end
         busy_from = t + 1;
         busy_to   = t + LANES;
      end
   endtask

   task automatic model_clear(input int t, input int colour);
      for (int a = 0; a < WORDS; a++)
         exp_q.push_back('{t + 1 + a, a, colour});
      done_at[t + WORDS + 1] = 1'b1;
      busy_from = t + 1;
      busy_to   = t + WORDS;
   endtask

   always @(negedge vga_clock) begin
      if (cyc >= 1) begin
         mon_busy = (cyc >= busy_from) && (cyc <= busy_to);
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            mon_e = exp_q.pop_front();
            check_output("wr_en", wr_en, 1);
            check_output("wr_address", wr_address, mon_e.addr);
            check_output("wr_data", wr_data, mon_e.data);
         end else begin
            check_output("wr_en_idle", wr_en, 0);
         end
         check_output("st_error", st_error, err_at.exists(cyc));
         check_output("clear_done", clear_done, done_at.exists(cyc));
         check_output("busy", busy, mon_busy);
         check_output("st_ready", st_bus.st_ready, !mon_busy && !clear_req);
      end
   end

   task automatic wait_accept(input int bound, output int t);
      t = -1;
      for (int n = 0; n < bound; n++) begin
         @(negedge vga_clock);
         if (st_bus.st_ready) begin
            t = cyc;
            break;
         end
      end
      if (t < 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL accept_timeout: store never accepted within %0d cycles", bound);
      end
   endtask

   task automatic apply_stimulus(input int x, input int y, input logic [31:0] data,
                                 input logic [3:0] mask, output int t);
      @(posedge vga_clock);
      #1;
      st_bus.st_valid = 1'b1;
      st_bus.st_x     = x[8:0];
      st_bus.st_y     = y[7:0];
      st_bus.st_data  = data;
      st_bus.st_mask  = mask;
      wait_accept(100000, t);
      if (t >= 0) model_store(t, x, y, data, mask);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) begin
         @(posedge vga_clock);
         #1;
         st_bus.st_valid = 1'b0;
         clear_req       = 1'b0;
      end
   endtask

   task automatic start_clear(input logic [7:0] colour, output int t);
      @(posedge vga_clock);
      #1;
      while (cyc <= busy_to) begin
         @(posedge vga_clock);
         #1;
      end
      clear_req    = 1'b1;
      clear_colour = colour;
      @(negedge vga_clock);
      t = cyc;
      model_clear(t, int'(colour));
      @(posedge vga_clock);
      #1;
      clear_req    = 1'b0;
      clear_colour = ~colour;
   endtask

   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int t1, t2, tc, ts, r, x, y, gap;
      logic [31:0] d;
      logic [3:0]  m;
      checks    = 0;
      errors    = 0;
      busy_from = 1;
      busy_to   = 0;
      reset           = 1'b1;
      clear_req       = 1'b0;
      clear_colour    = 8'h00;
      st_bus.st_valid = 1'b0;
      st_bus.st_x     = '0;
      st_bus.st_y     = '0;
      st_bus.st_data  = '0;
      st_bus.st_mask  = '0;
      repeat (3) @(posedge vga_clock);
      #1;
      reset = 1'b0;
      @(negedge vga_clock);
      check_output("reset_wr_en", wr_en, 0);
      check_output("reset_wr_address", wr_address, 0);
      check_output("reset_wr_data", wr_data, 0);
      check_output("reset_busy", busy, 0);
      check_output("reset_clear_done", clear_done, 0);
      check_output("reset_st_error", st_error, 0);

      apply_stimulus(10, 2, 32'h44332211, 4'b1111, t1);
      idle_cycles(5);
      @(negedge vga_clock);
      check_output("hold_wr_address", wr_address, 653);
      check_output("hold_wr_data", wr_data, 8'h44);

      apply_stimulus(318, 239, 32'hDDCCBBAA, 4'b1111, t1);
      apply_stimulus(0, 0, 32'h87654321, 4'b0101, t2);
      check_output("ready_after_store", t2, t1 + 5);

      apply_stimulus(320, 0, 32'h12345678, 4'b1111, t1);
      apply_stimulus(100, 50, 32'hCAFEF00D, 4'b1011, t2);
      check_output("ready_after_error", t2, t1 + 1);
      idle_cycles(2);

      for (int k = 0; k < 150; k++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      x = $urandom_range(0, 319);
         else if (r < 8) x = $urandom_range(314, 319);
         else            x = $urandom_range(320, 511);
         y = ($urandom_range(0, 9) == 0) ? $urandom_range(240, 255) : $urandom_range(0, 239);
         d = $urandom;
         m = 4'($urandom_range(0, 15));
         apply_stimulus(x, y, d, m, t1);
         gap = $urandom_range(0, 2);
         if (gap > 0) idle_cycles(gap);
      end
      idle_cycles(6);

      @(posedge vga_clock);
      #1;
      clear_req       = 1'b1;
      clear_colour    = 8'hA5;
      st_bus.st_valid = 1'b1;
      st_bus.st_x     = 9'd5;
      st_bus.st_y     = 8'd7;
      st_bus.st_data  = 32'h0F1E2D3C;
      st_bus.st_mask  = 4'b1111;
      @(negedge vga_clock);
      tc = cyc;
      model_clear(tc, 8'hA5);
      @(posedge vga_clock);
      #1;
      clear_req    = 1'b0;
      clear_colour = 8'h5A;
      wait_accept(100000, ts);
      check_output("pending_store_cycle", ts, tc + WORDS + 1);
      if (ts >= 0) model_store(ts, 5, 7, 32'h0F1E2D3C, 4'b1111);
      idle_cycles(6);

      start_clear(8'h3C, tc);
      while (cyc < tc + 1001) begin
         @(posedge vga_clock);
         #1;
      end
      reset = 1'b1;
      while (exp_q.size() > 0 && exp_q[$].cyc > cyc) void'(exp_q.pop_back());
      done_at.delete();
      busy_to = cyc;
      @(posedge vga_clock);
      #1;
      reset = 1'b0;
      @(negedge vga_clock);
      check_output("abort_wr_address", wr_address, 0);
      check_output("abort_wr_data", wr_data, 0);
      idle_cycles(20);

      check_output("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
